bit_stream_reader: RTL and testbench

Fixed-to-variable bit unpacker for the consumer end of the bit-packed stream path. It accepts fixed-width words on a valid/ready handshake, buffers them LSB-first, and serves variable-width field reads (1..MAX_FIELD_W bits) on a second handshake. It also supports byte-alignment of the read pointer and a synchronous flush. This is the counterpart of the variable-to-packed bit FIFO on the producer side, and sits in front of field decoders.

---
 rtl/bit_stream_reader.sv | 133 +++++++++++++
 tb/tb_bit_stream_reader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_stream_reader.sv
// Fixed-width word to variable-width field unpacker. Words are buffered LSB-first;
// fields are read from bit 0 with zero latency and consumed on the read handshake.
module bit_stream_reader #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned MAX_FIELD_W = 32,
    parameter int unsigned BUF_W       = 64,
    parameter int unsigned CNT_W       = 7,
    parameter int unsigned NB_W        = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WORD_W-1:0]      word_in,
    input  logic                   word_valid,
    output logic                   word_ready,
    input  logic                   rd_valid,
    input  logic [NB_W-1:0]        rd_num_bits,
    output logic                   rd_ready,
    output logic [MAX_FIELD_W-1:0] rd_data,
    output logic                   rd_error,
    input  logic                   align_req,
    output logic                   align_done,
    input  logic                   flush,
    output logic [CNT_W-1:0]       bits_avail,
    output logic [2:0]             bit_pos
);

    typedef enum logic [0:0] {StIdle, StAlign} state_e;

    state_e           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       bit_pos_q, bit_pos_d;
    logic             rd_error_q, rd_error_d;
    logic             align_done_q, align_done_d;

    logic                   nb_legal;
    logic                   word_fire;
    logic [2:0]             drop;
    logic [CNT_W-1:0]       consume;
    logic [CNT_W-1:0]       base;
    logic [BUF_W-1:0]       shifted;
    logic [MAX_FIELD_W-1:0] field_mask;

    assign nb_legal   = (rd_num_bits <= NB_W'(MAX_FIELD_W));
    assign word_ready = ~flush & (count_q <= CNT_W'(BUF_W - WORD_W));
    assign rd_ready   = ~flush & (state_q == StIdle) & (count_q >= CNT_W'(rd_num_bits)) & nb_legal;

    // A shift by the full field width yields zero, so the mask becomes all ones.
    assign field_mask = ~({MAX_FIELD_W{1'b1}} << rd_num_bits);
    assign rd_data    = buf_q[MAX_FIELD_W-1:0] & field_mask;

    // Bits still to discard to reach the next byte boundary.
    assign drop = 3'd0 - bit_pos_q;

    always_comb begin
        state_d      = state_q;
        bit_pos_d    = bit_pos_q;
        rd_error_d   = 1'b0;
        align_done_d = 1'b0;
        consume      = '0;
        word_fire    = 1'b0;
        shifted      = buf_q;
        base         = count_q;
        buf_d        = buf_q;
        count_d      = count_q;

        if (flush) begin
            state_d   = StIdle;
            bit_pos_d = '0;
            buf_d     = '0;
            count_d   = '0;
        end else begin
            rd_error_d = rd_valid & ~nb_legal;
            word_fire  = word_valid & word_ready;

            unique case (state_q)
                StIdle: begin
                    if (rd_valid && rd_ready) begin
                        consume   = CNT_W'(rd_num_bits);
                        bit_pos_d = bit_pos_q + rd_num_bits[2:0];
                    end
                    if (align_req) begin
                        state_d = StAlign;
                    end
                end
                StAlign: begin
                    if (count_q >= CNT_W'(drop)) begin
                        consume      = CNT_W'(drop);
                        bit_pos_d    = '0;
                        state_d      = StIdle;
                        align_done_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase

            // Bits above count are always zero, so the new word can be OR-ed in.
            shifted = buf_q >> consume;
            base    = count_q - consume;
            if (word_fire) begin
                buf_d   = shifted | (BUF_W'(word_in) << base);
                count_d = base + CNT_W'(WORD_W);
            end else begin
                buf_d   = shifted;
                count_d = base;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            buf_q        <= '0;
            count_q      <= '0;
            bit_pos_q    <= '0;
            rd_error_q   <= 1'b0;
            align_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            count_q      <= count_d;
            bit_pos_q    <= bit_pos_d;
            rd_error_q   <= rd_error_d;
            align_done_q <= align_done_d;
        end
    end

    assign rd_error   = rd_error_q;
    assign align_done = align_done_q;
    assign bits_avail = count_q;
    assign bit_pos    = bit_pos_q;

endmodule

// File: tb/tb_bit_stream_reader.sv
// Self-checking bench for bit_stream_reader: directed scenarios plus a randomized run
// against a bit-queue reference model.
module tb_bit_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        rd_valid;
    logic [5:0]  rd_num_bits;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_error;
    logic        align_req;
    logic        align_done;
    logic        flush;
    logic [6:0]  bits_avail;
    logic [2:0]  bit_pos;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stream as a queue of bits, oldest first.
    bit mq[$];
    int m_pos;
    bit m_align;
    bit m_err;
    bit m_done;

    always #5 clk = ~clk;

    bit_stream_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .rd_valid    (rd_valid),
        .rd_num_bits (rd_num_bits),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_error    (rd_error),
        .align_req   (align_req),
        .align_done  (align_done),
        .flush       (flush),
        .bits_avail  (bits_avail),
        .bit_pos     (bit_pos)
    );

    function automatic bit exp_wready();
        return !flush && mq.size() <= 32;
    endfunction

    function automatic bit exp_rready();
        return !flush && !m_align && mq.size() >= int'(rd_num_bits) && rd_num_bits <= 6'd32;
    endfunction

    function automatic logic [31:0] exp_data();
        logic [31:0] d = '0;
        for (int i = 0; i < int'(rd_num_bits) && i < 32; i++) d[i] = mq[i];
        return d;
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_pos = 0; m_align = 0; m_err = 0; m_done = 0;
    endfunction

    task automatic model_edge();
        int nb;
        int drop;
        bit wr;
        bit rr;
        nb = int'(rd_num_bits);
        wr = exp_wready();
        rr = exp_rready();
        if (flush) begin
            model_clear();
        end else begin
            m_err  = rd_valid && nb > 32;
            m_done = 0;
            if (m_align) begin
                drop = (8 - m_pos) % 8;
                if (mq.size() >= drop) begin
                    repeat (drop) void'(mq.pop_front());
                    m_pos = 0; m_align = 0; m_done = 1;
                end
            end else begin
                if (rd_valid && rr) begin
                    repeat (nb) void'(mq.pop_front());
                    m_pos = (m_pos + nb) % 8;
                end
                if (align_req) m_align = 1;
            end
            if (word_valid && wr) for (int i = 0; i < 32; i++) mq.push_back(word_in[i]);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        word_in = '0; word_valid = 0; rd_valid = 0; rd_num_bits = '0;
        align_req = 0; flush = 0;
    endtask

    task automatic do_flush();
        idle_inputs();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_clear();
        #12;
        n_tests++; if (bits_avail !== 7'd0) begin n_fail++; $display("FAIL reset_bits_avail got %0d want 0", bits_avail); end
        n_tests++; if (bit_pos !== 3'd0) begin n_fail++; $display("FAIL reset_bit_pos got %0d want 0", bit_pos); end
        n_tests++; if ({rd_error, align_done} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got %b want 00", {rd_error, align_done}); end
        n_tests++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL reset_word_ready got %b want 1", word_ready); end
        rd_num_bits = 6'd3; #1;
        n_tests++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ready3 got %b want 0", rd_ready); end
        rd_num_bits = 6'd0; #1;
        n_tests++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rd_ready0 got %b want 1", rd_ready); end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_read();
        idle_inputs();
        word_in = 32'hA5A50F0F; word_valid = 1;
        tick();
        word_valid = 0; rd_valid = 1; rd_num_bits = 6'd4; #1;
        n_tests++; if ({rd_ready, rd_data} !== {1'b1, 32'hF}) begin n_fail++; $display("FAIL basic_rd4 got %b/%h want 1/f", rd_ready, rd_data); end
        tick();
        n_tests++; if (bits_avail !== 7'd28) begin n_fail++; $display("FAIL basic_avail28 got %0d want 28", bits_avail); end
        rd_num_bits = 6'd12; #1;
        n_tests++; if ({rd_ready, rd_data} !== {1'b1, 32'h0F0}) begin n_fail++; $display("FAIL basic_rd12 got %b/%h want 1/0f0", rd_ready, rd_data); end
        tick();
        rd_valid = 0;
        n_tests++; if ({bit_pos, bits_avail} !== {3'd0, 7'd16}) begin n_fail++; $display("FAIL basic_pos got %0d/%0d want 0/16", bit_pos, bits_avail); end
        do_flush();
    endtask

    task automatic test_align();
        idle_inputs();
        word_in = 32'h12345678; word_valid = 1;
        tick();
        word_valid = 0; rd_valid = 1; rd_num_bits = 6'd3; #1;
        n_tests++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL align_rd3 got %h want 0", rd_data); end
        tick();
        rd_valid = 0;
        n_tests++; if (bit_pos !== 3'd3) begin n_fail++; $display("FAIL align_pos3 got %0d want 3", bit_pos); end
        align_req = 1;
        tick();
        align_req = 0; rd_num_bits = 6'd8; #1;
        n_tests++; if ({rd_ready, align_done} !== 2'b00) begin n_fail++; $display("FAIL align_busy got %b want 00", {rd_ready, align_done}); end
        tick();
        n_tests++; if ({align_done, bit_pos, bits_avail} !== {1'b1, 3'd0, 7'd24}) begin n_fail++; $display("FAIL align_done got %b/%0d/%0d want 1/0/24", align_done, bit_pos, bits_avail); end
        rd_valid = 1; #1;
        n_tests++; if ({rd_ready, rd_data} !== {1'b1, 32'h56}) begin n_fail++; $display("FAIL align_rd8 got %b/%h want 1/56", rd_ready, rd_data); end
        tick();
        rd_valid = 0;
        n_tests++; if (align_done !== 1'b0) begin n_fail++; $display("FAIL align_pulse got %b want 0", align_done); end
        do_flush();
    endtask

    task automatic test_underflow();
        idle_inputs();
        rd_valid = 1; rd_num_bits = 6'd5; #1;
        n_tests++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL under_stall got %b want 0", rd_ready); end
        tick();
        word_in = 32'h0000001F; word_valid = 1; #1;
        n_tests++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL under_same_cycle got %b want 0", rd_ready); end
        tick();
        word_valid = 0; #1;
        n_tests++; if ({rd_ready, rd_data} !== {1'b1, 32'h1F}) begin n_fail++; $display("FAIL under_go got %b/%h want 1/1f", rd_ready, rd_data); end
        tick();
        rd_valid = 0;
        n_tests++; if (bits_avail !== 7'd27) begin n_fail++; $display("FAIL under_avail got %0d want 27", bits_avail); end
        do_flush();
    endtask

    task automatic test_full_and_simultaneous();
        logic [31:0] w0;
        w0 = $urandom;
        idle_inputs();
        word_in = w0; word_valid = 1;
        tick();
        word_in = $urandom;
        tick();
        word_valid = 0;
        n_tests++; if ({bits_avail, word_ready} !== {7'd64, 1'b0}) begin n_fail++; $display("FAIL full_state got %0d/%b want 64/0", bits_avail, word_ready); end
        rd_valid = 1; rd_num_bits = 6'd32; #1;
        n_tests++; if (rd_data !== w0) begin n_fail++; $display("FAIL full_rd32 got %h want %h", rd_data, w0); end
        tick();
        rd_valid = 0;
        n_tests++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back got %b want 1", word_ready); end
        do_flush();
        word_in = 32'hAB000000; word_valid = 1;
        tick();
        word_valid = 0; rd_valid = 1; rd_num_bits = 6'd24;
        tick();
        rd_num_bits = 6'd8; word_in = 32'hDEADBEEF; word_valid = 1; #1;
        n_tests++; if ({rd_ready, word_ready, rd_data} !== {2'b11, 32'hAB}) begin n_fail++; $display("FAIL simul_rd8 got %b%b/%h want 11/ab", rd_ready, word_ready, rd_data); end
        tick();
        word_valid = 0; rd_num_bits = 6'd32; #1;
        n_tests++; if ({rd_ready, rd_data} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL simul_rd32 got %b/%h want 1/deadbeef", rd_ready, rd_data); end
        tick();
        rd_valid = 0;
        do_flush();
    endtask

    task automatic test_error();
        idle_inputs();
        word_in = $urandom; word_valid = 1;
        tick();
        word_valid = 0; rd_valid = 1; rd_num_bits = 6'd40; #1;
        n_tests++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL err_ready got %b want 0", rd_ready); end
        tick();
        rd_valid = 0;
        n_tests++; if ({rd_error, bits_avail} !== {1'b1, 7'd32}) begin n_fail++; $display("FAIL err_pulse got %b/%0d want 1/32", rd_error, bits_avail); end
        tick();
        n_tests++; if (rd_error !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", rd_error); end
        do_flush();
    endtask

    task automatic test_flush_and_reset();
        idle_inputs();
        word_in = $urandom; word_valid = 1;
        tick();
        word_valid = 0; rd_valid = 1; rd_num_bits = 6'd27;
        tick();
        rd_valid = 0; align_req = 1;
        tick();
        align_req = 0; flush = 1;
        tick();
        flush = 0; rd_num_bits = 6'd0; #1;
        n_tests++; if ({rd_ready, bits_avail, bit_pos, align_done} !== {1'b1, 7'd0, 3'd0, 1'b0}) begin n_fail++; $display("FAIL flush_state got %b/%0d/%0d/%b want 1/0/0/0", rd_ready, bits_avail, bit_pos, align_done); end
        tick();
        n_tests++; if (align_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done got %b want 0", align_done); end
        word_in = $urandom; word_valid = 1;
        tick();
        rd_valid = 1; rd_num_bits = 6'd5;
        tick();
        #2;
        rst_n = 0;
        model_clear();
        idle_inputs();
        rd_num_bits = 6'd4; #1;
        n_tests++; if ({bits_avail, bit_pos, rd_error, align_done, word_ready, rd_ready} !== {7'd0, 3'd0, 4'b0010}) begin n_fail++; $display("FAIL midreset got %0d/%0d/%b%b%b%b want 0/0/0010", bits_avail, bit_pos, rd_error, align_done, word_ready, rd_ready); end
        #2;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 1500; c++) begin
            word_in     = $urandom;
            word_valid  = ($urandom_range(0, 99) < 45);
            rd_valid    = ($urandom_range(0, 99) < 60);
            rd_num_bits = ($urandom_range(0, 99) < 8) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 32));
            align_req   = ($urandom_range(0, 99) < 6);
            flush       = ($urandom_range(0, 99) < 2);
            #1;
            n_tests++;
            if ({word_ready, rd_ready} !== {exp_wready(), exp_rready()} ||
                int'(bits_avail) != mq.size() || int'(bit_pos) != m_pos ||
                rd_error !== m_err || align_done !== m_done ||
                (exp_rready() && rd_data !== exp_data())) begin
                n_fail++;
                if (errs < 10) $display("FAIL rand_cycle%0d got wr%b rr%b avail%0d pos%0d err%b done%b data%h want wr%b rr%b avail%0d pos%0d err%b done%b data%h",
                    c, word_ready, rd_ready, bits_avail, bit_pos, rd_error, align_done, rd_data,
                    exp_wready(), exp_rready(), mq.size(), m_pos, m_err, m_done, exp_data());
                errs++;
            end
            tick();
        end
        do_flush();
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_align();
        test_underflow();
        test_full_and_simultaneous();
        test_error();
        test_flush_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
